// File: rtl/toast_fetch.sv
// toast_fetch: instruction fetch stage with IF/ID register and one-entry skid buffer
module toast_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        IMEM_rd_en_o,
    output logic [31:0] IMEM_addr_o,
    input  logic [31:0] IMEM_data_i,
    input  logic        ID_stall_i,
    input  logic        ID_branch_taken_i,
    input  logic [31:0] ID_pc_dest_i,
    output logic [31:0] ID_pc_o,
    output logic [31:0] ID_pc4_o,
    output logic [31:0] ID_instr_o,
    output logic        ID_valid_o,
    output logic        ID_misalign_o
);
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        inflight_valid_q, inflight_valid_d;
    logic        inflight_mis_q, inflight_mis_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        skid_mis_q, skid_mis_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_valid_q, id_valid_d;
    logic        id_mis_q, id_mis_d;
    logic        redirect;

    assign redirect     = ID_branch_taken_i && !ID_stall_i;
    assign IMEM_rd_en_o = !rst_i && !ID_stall_i;
    assign IMEM_addr_o  = redirect ? {ID_pc_dest_i[31:2], 2'b00} : fetch_pc_q;

    assign ID_pc_o       = id_pc_q;
    assign ID_pc4_o      = id_pc4_q;
    assign ID_instr_o    = id_instr_q;
    assign ID_valid_o    = id_valid_q;
    assign ID_misalign_o = id_mis_q;

    always_comb begin
        fetch_pc_d       = fetch_pc_q;
        inflight_pc_d    = inflight_pc_q;
        inflight_valid_d = inflight_valid_q;
        inflight_mis_d   = inflight_mis_q;
        skid_instr_d     = skid_instr_q;
        skid_pc_d        = skid_pc_q;
        skid_mis_d       = skid_mis_q;
        skid_valid_d     = skid_valid_q;
        id_pc_d          = id_pc_q;
        id_pc4_d         = id_pc4_q;
        id_instr_d       = id_instr_q;
        id_valid_d       = id_valid_q;
        id_mis_d         = id_mis_q;
        if (ID_stall_i) begin
            // The word returning this cycle would be lost otherwise; park it.
            if (inflight_valid_q) begin
                skid_instr_d = IMEM_data_i;
                skid_pc_d    = inflight_pc_q;
                skid_mis_d   = inflight_mis_q;
                skid_valid_d = 1'b1;
            end
            inflight_valid_d = 1'b0;
        end else begin
            fetch_pc_d       = IMEM_addr_o + 32'd4;
            inflight_pc_d    = IMEM_addr_o;
            inflight_valid_d = 1'b1;
            inflight_mis_d   = redirect && ID_pc_dest_i[1];
            if (redirect) begin
                skid_valid_d = 1'b0;
                id_valid_d   = 1'b0;
                id_instr_d   = NOP_INSTR;
                id_mis_d     = 1'b0;
            end else if (skid_valid_q) begin
                skid_valid_d = 1'b0;
                id_pc_d      = skid_pc_q;
                id_pc4_d     = skid_pc_q + 32'd4;
                id_instr_d   = skid_instr_q;
                id_valid_d   = 1'b1;
                id_mis_d     = skid_mis_q;
            end else if (inflight_valid_q) begin
                id_pc_d    = inflight_pc_q;
                id_pc4_d   = inflight_pc_q + 32'd4;
                id_instr_d = IMEM_data_i;
                id_valid_d = 1'b1;
                id_mis_d   = inflight_mis_q;
            end else begin
                id_valid_d = 1'b0;
                id_instr_d = NOP_INSTR;
                id_mis_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q       <= RESET_PC;
            inflight_pc_q    <= 32'd0;
            inflight_valid_q <= 1'b0;
            inflight_mis_q   <= 1'b0;
            skid_instr_q     <= NOP_INSTR;
            skid_pc_q        <= 32'd0;
            skid_mis_q       <= 1'b0;
            skid_valid_q     <= 1'b0;
            id_pc_q          <= 32'd0;
            id_pc4_q         <= 32'd4;
            id_instr_q       <= NOP_INSTR;
            id_valid_q       <= 1'b0;
            id_mis_q         <= 1'b0;
        end else begin
            fetch_pc_q       <= fetch_pc_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_mis_q   <= inflight_mis_d;
            skid_instr_q     <= skid_instr_d;
            skid_pc_q        <= skid_pc_d;
            skid_mis_q       <= skid_mis_d;
            skid_valid_q     <= skid_valid_d;
            id_pc_q          <= id_pc_d;
            id_pc4_q         <= id_pc4_d;
            id_instr_q       <= id_instr_d;
            id_valid_q       <= id_valid_d;
            id_mis_q         <= id_mis_d;
        end
    end
endmodule

// File: tb/tb_toast_fetch.sv
// tb_toast_fetch: directed self-checking bench for toast_fetch
module tb_toast_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        clk = 1'b0;
    logic        rst, stall, br;
    logic [31:0] dest;
    logic        rd_en;
    logic [31:0] addr, imem_data;
    logic [31:0] id_pc, id_pc4, id_instr;
    logic        id_valid, id_mis;
    int checks = 0;
    int errors = 0;

    toast_fetch dut (
        .clk_i(clk), .rst_i(rst),
        .IMEM_rd_en_o(rd_en), .IMEM_addr_o(addr), .IMEM_data_i(imem_data),
        .ID_stall_i(stall), .ID_branch_taken_i(br), .ID_pc_dest_i(dest),
        .ID_pc_o(id_pc), .ID_pc4_o(id_pc4), .ID_instr_o(id_instr),
        .ID_valid_o(id_valid), .ID_misalign_o(id_mis)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'hC000_0000 ^ a;
    endfunction

    // Unread cycles return garbage so a missing skid capture is visible.
    always @(posedge clk) imem_data <= rd_en ? instr_of(addr) : 32'hDEAD_DEAD;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; stall = 1'b0; br = 1'b0; dest = 32'd0;
        tick; tick;
        checks++;
        if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        checks++;
        if ({id_valid, id_pc, id_pc4, id_instr, id_mis} !== {1'b0, 32'd0, 32'd4, NOP, 1'b0}) begin
            errors++; $display("FAIL reset_id: got v=%b pc=%h pc4=%h i=%h m=%b", id_valid, id_pc, id_pc4, id_instr, id_mis);
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential;
        #1;
        checks++;
        if ({rd_en, addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL seq_addr0: got %b %h want 1 0", rd_en, addr); end
        tick;
        checks++;
        if ({id_valid, addr} !== {1'b0, 32'h4}) begin errors++; $display("FAIL seq_cycle1: got v=%b a=%h want 0 4", id_valid, addr); end
        tick;
        checks++;
        if ({id_valid, id_pc, id_pc4, id_instr, id_mis} !== {1'b1, 32'h0, 32'h4, instr_of(32'h0), 1'b0}) begin
            errors++; $display("FAIL seq_first: got v=%b pc=%h pc4=%h i=%h m=%b", id_valid, id_pc, id_pc4, id_instr, id_mis);
        end
        checks++;
        if (addr !== 32'h8) begin errors++; $display("FAIL seq_addr8: got %h want 8", addr); end
        for (int k = 1; k <= 2; k++) begin
            tick;
            checks++;
            if ({id_valid, id_pc, id_instr} !== {1'b1, 32'(4 * k), instr_of(32'(4 * k))}) begin
                errors++; $display("FAIL seq_pc%0d: got v=%b pc=%h i=%h", k, id_valid, id_pc, id_instr);
            end
        end
    endtask

    task automatic test_stall;
        stall = 1'b1;
        #1;
        checks++;
        if (rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd_en: got %b want 0", rd_en); end
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++;
            if ({rd_en, id_valid, id_pc, id_instr} !== {1'b0, 1'b1, 32'h8, instr_of(32'h8)}) begin
                errors++; $display("FAIL stall_hold%0d: got rd=%b v=%b pc=%h i=%h", k, rd_en, id_valid, id_pc, id_instr);
            end
        end
        stall = 1'b0;
        #1;
        checks++;
        if ({rd_en, addr} !== {1'b1, 32'h10}) begin errors++; $display("FAIL stall_resume_addr: got %b %h want 1 10", rd_en, addr); end
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++;
            if ({id_valid, id_pc, id_pc4, id_instr} !== {1'b1, 32'(12 + 4 * k), 32'(16 + 4 * k), instr_of(32'(12 + 4 * k))}) begin
                errors++; $display("FAIL stall_release%0d: got v=%b pc=%h pc4=%h i=%h", k, id_valid, id_pc, id_pc4, id_instr);
            end
        end
    endtask

    task automatic test_branch;
        tick;
        br = 1'b1; dest = 32'h100;
        #1;
        checks++;
        if ({rd_en, addr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL br_addr: got %b %h want 1 100", rd_en, addr); end
        tick;
        br = 1'b0;
        checks++;
        if ({id_valid, id_instr, id_mis} !== {1'b0, NOP, 1'b0}) begin
            errors++; $display("FAIL br_bubble: got v=%b i=%h m=%b", id_valid, id_instr, id_mis);
        end
        tick;
        checks++;
        if ({id_valid, id_pc, id_pc4, id_instr, id_mis} !== {1'b1, 32'h100, 32'h104, instr_of(32'h100), 1'b0}) begin
            errors++; $display("FAIL br_target: got v=%b pc=%h pc4=%h i=%h m=%b", id_valid, id_pc, id_pc4, id_instr, id_mis);
        end
        tick;
        checks++;
        if ({id_valid, id_pc} !== {1'b1, 32'h104}) begin errors++; $display("FAIL br_next: got v=%b pc=%h want 1 104", id_valid, id_pc); end
    endtask

    task automatic test_misalign;
        br = 1'b1; dest = 32'h203;
        #1;
        checks++;
        if (addr !== 32'h200) begin errors++; $display("FAIL mis_addr203: got %h want 200", addr); end
        tick;
        br = 1'b0;
        tick;
        checks++;
        if ({id_valid, id_pc, id_instr, id_mis} !== {1'b1, 32'h200, instr_of(32'h200), 1'b1}) begin
            errors++; $display("FAIL mis_set: got v=%b pc=%h i=%h m=%b", id_valid, id_pc, id_instr, id_mis);
        end
        tick;
        checks++;
        if ({id_valid, id_pc, id_mis} !== {1'b1, 32'h204, 1'b0}) begin
            errors++; $display("FAIL mis_seq_clear: got v=%b pc=%h m=%b", id_valid, id_pc, id_mis);
        end
        br = 1'b1; dest = 32'h201;
        #1;
        checks++;
        if (addr !== 32'h200) begin errors++; $display("FAIL mis_addr201: got %h want 200", addr); end
        tick;
        br = 1'b0;
        tick;
        checks++;
        if ({id_valid, id_pc, id_mis} !== {1'b1, 32'h200, 1'b0}) begin
            errors++; $display("FAIL mis_bit0_only: got v=%b pc=%h m=%b", id_valid, id_pc, id_mis);
        end
    endtask

    task automatic test_stall_and_branch;
        stall = 1'b1; br = 1'b1; dest = 32'h300;
        #1;
        checks++;
        if (rd_en !== 1'b0) begin errors++; $display("FAIL sb_rd_en: got %b want 0", rd_en); end
        tick;
        checks++;
        if ({id_valid, id_pc} !== {1'b1, 32'h200}) begin errors++; $display("FAIL sb_hold: got v=%b pc=%h want 1 200", id_valid, id_pc); end
        stall = 1'b0; br = 1'b0;
        #1;
        checks++;
        if (addr !== 32'h208) begin errors++; $display("FAIL sb_no_redirect: got %h want 208", addr); end
        tick;
        checks++;
        if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h204, instr_of(32'h204)}) begin
            errors++; $display("FAIL sb_skid: got v=%b pc=%h i=%h", id_valid, id_pc, id_instr);
        end
        br = 1'b1;
        #1;
        checks++;
        if (addr !== 32'h300) begin errors++; $display("FAIL sb_redirect_addr: got %h want 300", addr); end
        tick;
        br = 1'b0;
        checks++;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL sb_bubble: got v=%b want 0", id_valid); end
        tick;
        checks++;
        if ({id_valid, id_pc} !== {1'b1, 32'h300}) begin errors++; $display("FAIL sb_target: got v=%b pc=%h want 1 300", id_valid, id_pc); end
    endtask

    task automatic test_reset_mid_stall;
        stall = 1'b1;
        tick;
        rst = 1'b1;
        #1;
        checks++;
        if (rd_en !== 1'b0) begin errors++; $display("FAIL rs_rd_en: got %b want 0", rd_en); end
        tick;
        checks++;
        if ({id_valid, id_pc, id_instr} !== {1'b0, 32'h0, NOP}) begin
            errors++; $display("FAIL rs_cleared: got v=%b pc=%h i=%h", id_valid, id_pc, id_instr);
        end
        rst = 1'b0; stall = 1'b0;
        #1;
        checks++;
        if ({rd_en, addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL rs_restart: got %b %h want 1 0", rd_en, addr); end
        tick;
        checks++;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL rs_no_stale: got v=%b pc=%h", id_valid, id_pc); end
        tick;
        checks++;
        if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h0, instr_of(32'h0)}) begin
            errors++; $display("FAIL rs_first: got v=%b pc=%h i=%h", id_valid, id_pc, id_instr);
        end
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_stall;
        test_branch;
        test_misalign;
        test_stall_and_branch;
        test_reset_mid_stall;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/toast_fetch.md
Name: toast_fetch

Overview:
- Instruction-fetch stage and IF/ID pipeline register. Sits directly upstream of the decode stage and the branch target generator.
- Owns the PC register and drives a synchronous instruction memory with a 1-cycle read latency.
- Accepts the resolved branch target from decode and redirects fetch.
- Presents registered PC, PC+4 and instruction to ID. Includes a one-entry skid buffer so that no fetched word is lost under a stall.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding driven on ID_instr_o when invalid (ADDI x0,x0,0).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- IMEM_rd_en_o  out  1  read request; data returns on IMEM_data_i next cycle.
- IMEM_addr_o  out  32  word-aligned fetch address.
- IMEM_data_i  in  32  read data for the request issued in the previous cycle.
- ID_stall_i  in  1  hazard stall: hold IF/ID and PC.
- ID_branch_taken_i  in  1  redirect request from decode.
- ID_pc_dest_i  in  32  branch/jump target from the branch target generator.
- ID_pc_o  out  32  PC of instruction in ID.
- ID_pc4_o  out  32  ID_pc_o + 4.
- ID_instr_o  out  32  instruction in ID.
- ID_valid_o  out  1  ID holds a real instruction.
- ID_misalign_o  out  1  instruction was fetched via a target with bit 1 set.

Behaviour:

Reset
- Reset is synchronous: fetch_pc <= RESET_PC; inflight_valid, skid_valid, ID_valid_o, ID_misalign_o <= 0; ID_instr_o <= NOP_INSTR; ID_pc_o <= 0; ID_pc4_o <= 4.
- IMEM_rd_en_o = 0 while rst_i = 1.
- Reset overrides all other inputs.
- Reset asserted mid-stall or mid-redirect discards all in-flight and skid state.

Internal state
- fetch_pc: next address to issue.
- inflight_pc / inflight_valid / inflight_mis: tracks the request issued last cycle.
- skid_instr / skid_pc / skid_mis / skid_valid: one-entry holding buffer.

Normal cycle (rst_i = 0, ID_stall_i = 0, ID_branch_taken_i = 0)
- IMEM_rd_en_o = 1 and IMEM_addr_o = fetch_pc.
- fetch_pc <= fetch_pc + 4, mod 2^32; 0xFFFF_FFFC wraps to 0.
- inflight <= {fetch_pc, 1}.
- IF/ID load source:
  - skid_valid: load from skid, clear skid_valid.
  - else inflight_valid: load {inflight_pc, IMEM_data_i}.
  - else: load a bubble (ID_valid_o = 0, ID_instr_o = NOP_INSTR).
- Latency: an address issued at edge N appears on ID outputs after edge N+2. Steady-state throughput is 1 instruction per cycle.

Stall (ID_stall_i = 1)
- IMEM_rd_en_o = 0; fetch_pc and IF/ID registers hold.
- ID_branch_taken_i is ignored while stalled.
- If inflight_valid, capture IMEM_data_i and inflight_pc into the skid buffer (skid_valid <= 1), then inflight_valid <= 0.
- Skid cannot overflow: no request is issued while stalled.
- Multi-cycle stalls hold the skid unchanged.

Redirect (ID_branch_taken_i = 1, ID_stall_i = 0)
- Target: tgt = {ID_pc_dest_i[31:1], 1'b0}, i.e. bit 0 cleared per JALR rules.
- Same cycle: IMEM_rd_en_o = 1 and IMEM_addr_o = {tgt[31:2], 2'b00}. This is a combinational path from ID_pc_dest_i.
- fetch_pc <= {tgt[31:2], 2'b00} + 4.
- inflight <= {tgt aligned, 1}, with inflight_mis <= tgt[1].
- Wrong-path squash: the inflight word and the skid are discarded (skid_valid <= 0).
- IF/ID loads a bubble.
- Penalty: exactly 1 bubble cycle.

Misaligned target
- ID_misalign_o travels with the instruction fetched at the redirect target.
- Sequential fetches always have ID_misalign_o = 0.

Test Plan:
- Reset release, no stalls -> IMEM_addr_o sequence 0, 4, 8, ...; ID_valid_o first high 2 cycles after release with ID_pc_o = 0, ID_pc4_o = 4, ID_instr_o = mem[0].
- Stall for 3 cycles while ID holds pc 0x8 -> no IMEM read during the stall; on release ID shows pc 0xC (from skid), then 0x10; no duplicated or lost PCs.
- Taken branch with ID_pc_dest_i = 0x100 while fetch_pc = 0x20 -> IMEM_addr_o = 0x100 that cycle; one bubble (ID_valid_o = 0, NOP_INSTR); next ID_pc_o = 0x100, then 0x104.
- ID_pc_dest_i = 0x203 -> fetch 0x200, ID_misalign_o = 1 for that instruction only; 0x201 -> fetch 0x200, ID_misalign_o = 0.
- ID_stall_i and ID_branch_taken_i both high -> no redirect, skid captured; branch reasserted after the stall redirects normally.
- rst_i asserted during a stall with skid_valid = 1 -> next cycle ID_valid_o = 0; fetch restarts at RESET_PC; no stale skid word reaches ID.
